// File: rtl/binary_bbox_detect_pkg.sv
// Shared definitions for the binarized-video measurement stages: FSM states and
// default image geometry.
package binary_bbox_detect_pkg;

   localparam int IMG_HDISP_DEFAULT = 640;
   localparam int IMG_VDISP_DEFAULT = 480;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      COMMIT = 2'd2
   } bbox_state_t;

endpackage

// File: rtl/binary_bbox_detect_video_sync_edge.sv
// Registers vsync/href and flags their edges; reusable by any stream stage.
module video_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic i_vsync,
   input  logic i_href,
   output logic o_vsync_rise,
   output logic o_vsync_fall,
   output logic o_href_fall
);

   logic r_vsync_d;
   logic r_href_d;

   // Resetting the history high means a frame already running at reset
   // release never shows up as a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_d <= 1'b1;
         r_href_d  <= 1'b1;
      end else begin
         r_vsync_d <= i_vsync;
         r_href_d  <= i_href;
      end
   end

   assign o_vsync_rise = i_vsync & ~r_vsync_d;
   assign o_vsync_fall = ~i_vsync & r_vsync_d;
   assign o_href_fall  = ~i_href & r_href_d;

endmodule

// File: rtl/binary_bbox_detect.sv
// Per-frame foreground bounding box / pixel count with 1-clk video pass-through.
// Optional perimeter overlay of the previous box on post_img_Bit: BBOX_OVERLAY_EN.
module binary_bbox_detect
   import binary_bbox_detect_pkg::*;
#(
   parameter int IMG_HDISP  = IMG_HDISP_DEFAULT,
   parameter int IMG_VDISP  = IMG_VDISP_DEFAULT,
   parameter int CW         = 10,
   parameter int MIN_PIXELS = 16,
   parameter int PCW        = 19
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           per_frame_vsync,
   input  logic           per_frame_href,
   input  logic           per_frame_clken,
   input  logic           per_img_Bit,
   output logic           post_frame_vsync,
   output logic           post_frame_href,
   output logic           post_frame_clken,
   output logic           post_img_Bit,
   output logic [CW-1:0]  box_x_min,
   output logic [CW-1:0]  box_x_max,
   output logic [CW-1:0]  box_y_min,
   output logic [CW-1:0]  box_y_max,
   output logic [PCW-1:0] box_pix_cnt,
   output logic           box_valid,
   output logic           frame_done
);

   localparam logic [CW:0]    LP_HDISP = (CW+1)'(IMG_HDISP);
   localparam logic [CW:0]    LP_VDISP = (CW+1)'(IMG_VDISP);
   localparam logic [PCW-1:0] LP_MINPX = PCW'(MIN_PIXELS);

   logic w_vs_rise, w_vs_fall, w_href_fall;
   bbox_state_t r_state, w_state_next;
   logic w_commit, w_start, w_pix, w_in_img, w_count, w_valid;
   logic r_rise_pend;
   // One spare bit so the counters can sit at IMG_HDISP/IMG_VDISP without wrapping.
   logic [CW:0]    r_col, r_row;
   logic [CW-1:0]  w_col, w_row;
   logic [CW-1:0]  r_x_min, r_x_max, r_y_min, r_y_max;
   logic [PCW-1:0] r_cnt;
   logic [CW-1:0]  r_box_x_min, r_box_x_max, r_box_y_min, r_box_y_max;
   logic [PCW-1:0] r_box_cnt;
   logic r_box_valid, r_frame_done;
   logic r_post_vsync, r_post_href, r_post_clken, r_post_bit;
   logic w_overlay;

   video_sync_edge u_sync_edge (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_vsync      (per_frame_vsync),
      .i_href       (per_frame_href),
      .o_vsync_rise (w_vs_rise),
      .o_vsync_fall (w_vs_fall),
      .o_href_fall  (w_href_fall)
   );

   assign w_start  = w_vs_rise | r_rise_pend;
   assign w_pix    = per_frame_href & per_frame_clken;
   assign w_col    = r_col[CW-1:0];
   assign w_row    = r_row[CW-1:0];
   assign w_in_img = (r_col < LP_HDISP) && (r_row < LP_VDISP);
   assign w_count  = (r_state == ACTIVE) && !w_vs_fall && w_pix && per_img_Bit && w_in_img;
   assign w_valid  = (r_cnt >= LP_MINPX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_commit     = 1'b0;
      case (r_state)
         IDLE:    if (w_start) w_state_next = ACTIVE;
         ACTIVE:  if (w_vs_fall) begin
                     w_state_next = COMMIT;
                     w_commit     = 1'b1;
                  end
         COMMIT:  w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // A rise seen outside IDLE (typically during COMMIT) is held for IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_rise_pend <= 1'b0;
      else if (r_state == IDLE)   r_rise_pend <= 1'b0;
      else if (w_vs_rise)         r_rise_pend <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col   <= '0;
         r_row   <= '0;
         r_x_min <= '0;
         r_x_max <= '0;
         r_y_min <= '0;
         r_y_max <= '0;
         r_cnt   <= '0;
      end else if (r_state == IDLE) begin
         if (w_start) begin
            r_col   <= '0;
            r_row   <= '0;
            r_x_min <= '1;
            r_x_max <= '0;
            r_y_min <= '1;
            r_y_max <= '0;
            r_cnt   <= '0;
         end
      end else if (r_state == ACTIVE) begin
         if (w_href_fall) begin
            r_col <= '0;
            if (r_row < LP_VDISP) r_row <= r_row + 1'b1;
         end else if (w_pix && (r_col < LP_HDISP)) begin
            r_col <= r_col + 1'b1;
         end
         if (w_count) begin
            if (w_col < r_x_min) r_x_min <= w_col;
            if (w_col > r_x_max) r_x_max <= w_col;
            if (w_row < r_y_min) r_y_min <= w_row;
            if (w_row > r_y_max) r_y_max <= w_row;
            if (r_cnt != '1)     r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   // Results land on the edge entering COMMIT, so they are visible with frame_done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_box_x_min  <= '0;
         r_box_x_max  <= '0;
         r_box_y_min  <= '0;
         r_box_y_max  <= '0;
         r_box_cnt    <= '0;
         r_box_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_commit;
         if (w_commit) begin
            r_box_x_min <= w_valid ? r_x_min : '0;
            r_box_x_max <= w_valid ? r_x_max : '0;
            r_box_y_min <= w_valid ? r_y_min : '0;
            r_box_y_max <= w_valid ? r_y_max : '0;
            r_box_cnt   <= r_cnt;
            r_box_valid <= w_valid;
         end
      end
   end

`ifdef BBOX_OVERLAY_EN
   logic w_in_x, w_in_y, w_on_edge;
   assign w_in_x    = (w_col >= r_box_x_min) && (w_col <= r_box_x_max);
   assign w_in_y    = (w_row >= r_box_y_min) && (w_row <= r_box_y_max);
   assign w_on_edge = (w_in_x && ((w_row == r_box_y_min) || (w_row == r_box_y_max))) ||
                      (w_in_y && ((w_col == r_box_x_min) || (w_col == r_box_x_max)));
   assign w_overlay = r_box_valid && (r_state == ACTIVE) && w_pix && w_in_img && w_on_edge;
`else
   assign w_overlay = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_post_vsync <= 1'b0;
         r_post_href  <= 1'b0;
         r_post_clken <= 1'b0;
         r_post_bit   <= 1'b0;
      end else begin
         r_post_vsync <= per_frame_vsync;
         r_post_href  <= per_frame_href;
         r_post_clken <= per_frame_clken;
         r_post_bit   <= per_img_Bit | w_overlay;
      end
   end

   assign post_frame_vsync = r_post_vsync;
   assign post_frame_href  = r_post_href;
   assign post_frame_clken = r_post_clken;
   assign post_img_Bit     = r_post_bit;
   assign box_x_min        = r_box_x_min;
   assign box_x_max        = r_box_x_max;
   assign box_y_min        = r_box_y_min;
   assign box_y_max        = r_box_y_max;
   assign box_pix_cnt      = r_box_cnt;
   assign box_valid        = r_box_valid;
   assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_binary_bbox_detect.sv
// Bench for binary_bbox_detect: table-driven frames, hand sequences for edge cases,
// randomized frames against a per-pixel model, and a cycle-by-cycle pass-through monitor.
module tb_binary_bbox_detect;

   localparam int HD  = 16;
   localparam int VD  = 8;
   localparam int CW  = 10;
   localparam int PCW = 19;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic vs = 1'b0, hr = 1'b0, ce = 1'b0, bt = 1'b0;

   logic a_pvs, a_phr, a_pce, a_pbt, a_valid, a_done;
   logic [CW-1:0] a_xmin, a_xmax, a_ymin, a_ymax;
   logic [PCW-1:0] a_cnt;
   logic b_pvs, b_phr, b_pce, b_pbt, b_valid, b_done;
   logic [CW-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
   logic [PCW-1:0] b_cnt;

   always #5 clk = ~clk;

   binary_bbox_detect #(.IMG_HDISP(HD), .IMG_VDISP(VD), .CW(CW), .MIN_PIXELS(4), .PCW(PCW)) u_a (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_Bit(bt),
      .post_frame_vsync(a_pvs), .post_frame_href(a_phr), .post_frame_clken(a_pce), .post_img_Bit(a_pbt),
      .box_x_min(a_xmin), .box_x_max(a_xmax), .box_y_min(a_ymin), .box_y_max(a_ymax),
      .box_pix_cnt(a_cnt), .box_valid(a_valid), .frame_done(a_done));

   binary_bbox_detect #(.IMG_HDISP(HD), .IMG_VDISP(VD), .CW(CW), .MIN_PIXELS(1), .PCW(PCW)) u_b (
      .clk(clk), .rst_n(rst_n),
      .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_Bit(bt),
      .post_frame_vsync(b_pvs), .post_frame_href(b_phr), .post_frame_clken(b_pce), .post_img_Bit(b_pbt),
      .box_x_min(b_xmin), .box_x_max(b_xmax), .box_y_min(b_ymin), .box_y_max(b_ymax),
      .box_pix_cnt(b_cnt), .box_valid(b_valid), .frame_done(b_done));

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Pass-through monitor: each post_* must equal the input seen at the previous edge.
   logic e_vs, e_hr, e_ce, e_bt;
   bit   mon_en = 1'b0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) {e_vs, e_hr, e_ce, e_bt} <= 4'b0;
      else        {e_vs, e_hr, e_ce, e_bt} <= {vs, hr, ce, bt};
   end
   always @(negedge clk) begin
      if (mon_en) begin
         chk("pass_vsync", a_pvs, e_vs);
         chk("pass_href",  a_phr, e_hr);
         chk("pass_clken", a_pce, e_ce);
`ifndef BBOX_OVERLAY_EN
         chk("pass_bit",   a_pbt, e_bt);
`endif
      end
   end

   // Reference model: box/count over qualified pixels inside the active window.
   int m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
   bit probe_bit;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      chk("midrst_cnt",   a_cnt, 0);
      chk("midrst_done",  a_done, 0);
      chk("midrst_valid", a_valid, 0);
      chk("midrst_pvs",   a_pvs, 0);
      step();
      rst_n = 1'b1;
   endtask

   task automatic begin_frame();
      m_cnt = 0; m_xmin = 1 << 30; m_xmax = -1; m_ymin = 1 << 30; m_ymax = -1;
      vs = 1'b1; hr = 1'b0; ce = 1'b0; bt = 1'b0;
      repeat (3) step();
   endtask

   // dens < 0: rectangle x0..x1 / y0..y1 is foreground; otherwise random with dens % density.
   task automatic send_lines(input int nl, input int lw, input int x0, input int x1,
                             input int y0, input int y1, input int dens, input bit gaps,
                             input int rst_line);
      bit px;
      for (int r = 0; r < nl; r++) begin
         for (int q = 0; q < lw; q++) begin
            if (gaps) begin
               while ($urandom_range(0, 99) < 30) begin
                  hr = 1'b1; ce = 1'b0; bt = 1'($urandom_range(0, 1));
                  step();
               end
            end
            if (dens < 0) px = (r >= y0 && r <= y1 && q >= x0 && q <= x1);
            else          px = ($urandom_range(0, 99) < dens);
            hr = 1'b1; ce = 1'b1; bt = px;
            if (px && q < HD && r < VD) begin
               m_cnt++;
               if (q < m_xmin) m_xmin = q;
               if (q > m_xmax) m_xmax = q;
               if (r < m_ymin) m_ymin = r;
               if (r > m_ymax) m_ymax = r;
            end
            step();
`ifdef BBOX_OVERLAY_EN
            if (r == 3 && q == 5) probe_bit = a_pbt;
`endif
            if (r == rst_line && q == 4) do_reset();
         end
         hr = 1'b0; ce = 1'($urandom_range(0, 1)); bt = 1'($urandom_range(0, 1));
         step();
         step();
         ce = 1'b0; bt = 1'b0;
         step();
      end
   endtask

   task automatic end_frame(input string tag, input bit last_px, input bit b2b);
      vs = 1'b0; hr = last_px; ce = last_px; bt = last_px;
      step();
      hr = 1'b0; ce = 1'b0; bt = 1'b0;
      chk({tag, "_done_timing"}, a_done, 1);
      chk({tag, "_b_done_timing"}, b_done, 1);
      for (int i = 0; i < 10 && a_done !== 1'b1; i++) step();
      if (b2b) vs = 1'b1;
      step();
      chk({tag, "_done_pulse"}, a_done, 0);
   endtask

   task automatic chk_box(input string tag, input bit use_b, input int exmin, input int exmax,
                          input int eymin, input int eymax, input int ecnt, input int evalid);
      chk({tag, "_xmin"},  use_b ? b_xmin  : a_xmin,  exmin);
      chk({tag, "_xmax"},  use_b ? b_xmax  : a_xmax,  exmax);
      chk({tag, "_ymin"},  use_b ? b_ymin  : a_ymin,  eymin);
      chk({tag, "_ymax"},  use_b ? b_ymax  : a_ymax,  eymax);
      chk({tag, "_cnt"},   use_b ? b_cnt   : a_cnt,   ecnt);
      chk({tag, "_valid"}, use_b ? b_valid : a_valid, evalid);
      $display("frame %s dut%s: x %0d..%0d y %0d..%0d cnt=%0d valid=%0d", tag, use_b ? "B" : "A",
               use_b ? b_xmin : a_xmin, use_b ? b_xmax : a_xmax,
               use_b ? b_ymin : a_ymin, use_b ? b_ymax : a_ymax,
               use_b ? b_cnt : a_cnt, use_b ? b_valid : a_valid);
   endtask

   task automatic chk_model(input string tag, input bit use_b, input int thr);
      bit v;
      v = (m_cnt >= thr);
      chk_box(tag, use_b, v ? m_xmin : 0, v ? m_xmax : 0, v ? m_ymin : 0, v ? m_ymax : 0,
              m_cnt, int'(v));
   endtask

   typedef struct {
      int nl, lw, x0, x1, y0, y1;
      int xmin, xmax, ymin, ymax, cnt, valid;
   } vec_t;
   vec_t tbl[6];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      tbl[0] = '{8, 16,  5,  9,  2,  4,   5,  9, 2, 4,  15, 1};
      tbl[1] = '{8, 16,  3,  5,  1,  1,   0,  0, 0, 0,   3, 0};
      tbl[2] = '{8, 20,  0, 19,  0,  7,   0, 15, 0, 7, 128, 1};
      tbl[3] = '{10, 20, 12, 19, 6,  9,  12, 15, 6, 7,   8, 1};
      tbl[4] = '{8, 16, 20, 20, 20, 20,   0,  0, 0, 0,   0, 0};
      tbl[5] = '{8, 16,  0,  1,  0,  1,   0,  1, 0, 1,   4, 1};

      repeat (3) step();
      chk("rst_pvs", a_pvs, 0);   chk("rst_phr", a_phr, 0);
      chk("rst_pce", a_pce, 0);   chk("rst_pbt", a_pbt, 0);
      chk("rst_xmin", a_xmin, 0); chk("rst_xmax", a_xmax, 0);
      chk("rst_ymin", a_ymin, 0); chk("rst_ymax", a_ymax, 0);
      chk("rst_cnt", a_cnt, 0);   chk("rst_valid", a_valid, 0);
      chk("rst_done", a_done, 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (3) step();

      for (int i = 0; i < 6; i++) begin
         begin_frame();
         send_lines(tbl[i].nl, tbl[i].lw, tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, -1, 1'b0, -1);
         end_frame($sformatf("tbl%0d", i), 1'b0, 1'b0);
         chk_box($sformatf("tbl%0d", i), 1'b0, tbl[i].xmin, tbl[i].xmax, tbl[i].ymin,
                 tbl[i].ymax, tbl[i].cnt, tbl[i].valid);
`ifdef BBOX_OVERLAY_EN
         if (i == 1) chk("overlay_5_3", probe_bit, 1);
`endif
         repeat (4) step();
      end

      // Pixel arriving with the vsync falling edge must not be counted.
      begin_frame();
      send_lines(1, 16, 0, 3, 0, 0, -1, 1'b0, -1);
      end_frame("fallpx", 1'b1, 1'b0);
      chk_box("fallpx", 1'b0, 0, 3, 0, 0, 4, 1);
      repeat (4) step();

      // Back-to-back frames with a single low vsync cycle between them.
      begin_frame();
      send_lines(8, 16, 2, 6, 1, 3, -1, 1'b0, -1);
      end_frame("b2b_1", 1'b0, 1'b1);
      chk_box("b2b_1", 1'b0, 2, 6, 1, 3, 15, 1);
      begin_frame();
      send_lines(8, 16, 10, 12, 5, 6, -1, 1'b0, -1);
      end_frame("b2b_2", 1'b0, 1'b0);
      chk_box("b2b_2", 1'b0, 10, 12, 5, 6, 6, 1);
      repeat (4) step();

      // Reset during row 3: the interrupted frame is never committed.
      begin_frame();
      send_lines(8, 16, 0, 15, 0, 7, -1, 1'b0, 3);
      vs = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         step();
         if (a_done) seen = 1'b1;
      end
      chk("no_partial_commit", seen, 0);
      chk("cnt_after_reset", a_cnt, 0);
      begin_frame();
      send_lines(8, 16, 7, 7, 6, 6, -1, 1'b0, -1);
      end_frame("postrst", 1'b0, 1'b0);
      chk_box("postrst", 1'b1, 7, 7, 6, 6, 1, 1);
      chk_box("postrst", 1'b0, 0, 0, 0, 0, 1, 0);
      repeat (4) step();

      // Randomized frames with clken gaps, checked on both thresholds.
      for (int f = 0; f < 6; f++) begin
         begin_frame();
         send_lines($urandom_range(6, 10), $urandom_range(14, 20), 0, 0, 0, 0,
                    $urandom_range(1, 40), 1'b1, -1);
         end_frame($sformatf("rnd%0d", f), 1'b0, 1'b0);
         chk_model($sformatf("rnd%0d", f), 1'b0, 4);
         chk_model($sformatf("rnd%0d", f), 1'b1, 1);
         repeat (3) step();
      end

      // Fully random pass-through traffic; only the monitor judges this phase.
      repeat (400) begin
         {vs, hr, ce, bt} = 4'($urandom_range(0, 15));
         step();
      end
      {vs, hr, ce, bt} = 4'b0;
      repeat (4) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
